// File: rtl/mmcm_drp_sequencer.sv
// mmcm_drp_sequencer: power-up lock sequencing and run-time rewrite of one
// MMCM output divider over DRP (read-modify-write of the Reg1/Reg2 pair),
// with the MMCM held in reset during the rewrite.
//
// DRP handshake: den (with dwe for writes) is a one-cycle request strobe;
// drdy is the one-cycle completion. daddr and di stay stable from den until
// drdy, and no new den is issued before drdy of the previous access.
module mmcm_drp_sequencer #(
    parameter int DRP_TIMEOUT  = 64,
    parameter int LOCK_TIMEOUT = 4000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_req,
    input  logic [2:0]  cfg_out_sel,
    input  logic [7:0]  cfg_divide,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic        clk_good,
    output logic        sys_rst,
    output logic        mmcm_rst,
    input  logic        mmcm_locked,
    output logic [6:0]  daddr,
    output logic        den,
    output logic        dwe,
    output logic [15:0] di,
    input  logic [15:0] do_i,
    input  logic        drdy,
    output logic [3:0]  dbg_state
);

    localparam int TMAX = (DRP_TIMEOUT > LOCK_TIMEOUT) ? DRP_TIMEOUT : LOCK_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [3:0] {
        S_POR       = 4'd0,
        S_WAIT_LOCK = 4'd1,
        S_IDLE      = 4'd2,
        S_RST_ON    = 4'd3,
        S_RD1       = 4'd4,
        S_WAIT_RD1  = 4'd5,
        S_WR1       = 4'd6,
        S_WAIT_WR1  = 4'd7,
        S_RD2       = 4'd8,
        S_WAIT_RD2  = 4'd9,
        S_WR2       = 4'd10,
        S_WAIT_WR2  = 4'd11,
        S_RELEASE   = 4'd12,
        S_DONE      = 4'd13
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic          lock_seen_q, lock_seen_d;
    logic          por_q, por_d;
    logic [2:0]    sel_q, sel_d;
    logic [7:0]    div_q, div_d;
    logic [1:0]    pend_err_q, pend_err_d;
    logic [1:0]    err_q, err_d;
    logic          done_q, done_d;
    logic          mmcm_rst_q, mmcm_rst_d;
    logic          den_q, den_d;
    logic          dwe_q, dwe_d;
    logic [6:0]    daddr_q, daddr_d;
    logic [15:0]   di_q, di_d;

    // Reg1 address for each output; Reg2 is always Reg1 + 1 (Reg1 is even).
    function automatic logic [6:0] reg1_addr(input logic [2:0] sel);
        case (sel)
            3'd0:    reg1_addr = 7'h08;
            3'd1:    reg1_addr = 7'h0A;
            3'd2:    reg1_addr = 7'h0C;
            3'd3:    reg1_addr = 7'h0E;
            3'd4:    reg1_addr = 7'h10;
            3'd5:    reg1_addr = 7'h06;
            default: reg1_addr = 7'h12;
        endcase
    endfunction

    // High/low counts in bits 11:6 / 5:0; a count of 64 wraps to 0 in 6 bits.
    function automatic logic [15:0] merge_reg1(input logic [15:0] rd, input logic [7:0] d);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = d >> 1;
        lo = d - hi;
        if (d == 8'd1) begin
            hi = 8'd1;
            lo = 8'd1;
        end
        merge_reg1 = (rd & 16'hF000) | {4'b0000, hi[5:0], lo[5:0]};
    endfunction

    // Edge in bit 7, no_count in bit 6; divide-by-1 uses no_count with edge clear.
    function automatic logic [15:0] merge_reg2(input logic [15:0] rd, input logic [7:0] d);
        logic edge_bit;
        logic no_count;
        no_count   = (d == 8'd1);
        edge_bit   = d[0] & ~no_count;
        merge_reg2 = (rd & 16'hFF3F) | {8'h00, edge_bit, no_count, 6'b000000};
    endfunction

    function automatic logic is_wait(input state_t s);
        is_wait = (s == S_WAIT_RD1) || (s == S_WAIT_WR1) || (s == S_WAIT_RD2) ||
                  (s == S_WAIT_WR2) || (s == S_WAIT_LOCK);
    endfunction

    // Next-state, timers and registered-output next values.
    always_comb begin
        state_d     = state_q;
        sync1_d     = mmcm_locked;
        sync2_d     = sync1_q;
        lock_seen_d = (state_q == S_WAIT_LOCK) && sync2_q;
        por_d       = por_q;
        sel_d       = sel_q;
        div_d       = div_q;
        pend_err_d  = pend_err_q;
        timer_d     = '0;

        case (state_q)
            S_POR:      state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (sync2_q && lock_seen_q) begin
                    state_d = por_q ? S_IDLE : S_DONE;
                end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                    if (pend_err_q == 2'd0) pend_err_d = 2'd3;
                    state_d = S_DONE;
                end
            end
            S_IDLE: begin
                if (cfg_req) begin
                    sel_d      = cfg_out_sel;
                    div_d      = cfg_divide;
                    pend_err_d = 2'd0;
                    if ((cfg_out_sel == 3'd7) || (cfg_divide == 8'd0) || (cfg_divide > 8'd128)) begin
                        pend_err_d = 2'd1;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_RST_ON;
                    end
                end
            end
            S_RST_ON:   state_d = S_RD1;
            S_RD1:      state_d = S_WAIT_RD1;
            S_WR1:      state_d = S_WAIT_WR1;
            S_RD2:      state_d = S_WAIT_RD2;
            S_WR2:      state_d = S_WAIT_WR2;
            S_WAIT_RD1, S_WAIT_WR1, S_WAIT_RD2, S_WAIT_WR2: begin
                // drdy is checked first so it wins over a simultaneous timeout
                if (drdy) begin
                    case (state_q)
                        S_WAIT_RD1: state_d = S_WR1;
                        S_WAIT_WR1: state_d = S_RD2;
                        S_WAIT_RD2: state_d = S_WR2;
                        default:    state_d = S_RELEASE;
                    endcase
                end else if (timer_q == TW'(DRP_TIMEOUT - 1)) begin
                    pend_err_d = 2'd2;
                    state_d    = S_RELEASE;
                end
            end
            S_RELEASE:  state_d = S_WAIT_LOCK;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_POR;
        endcase

        if ((state_d == state_q) && is_wait(state_q)) timer_d = timer_q + TW'(1);
        if ((state_q == S_WAIT_LOCK) && (state_d != S_WAIT_LOCK)) por_d = 1'b0;

        mmcm_rst_d = (state_d == S_RST_ON) || (state_d == S_RD1) || (state_d == S_WAIT_RD1) ||
                     (state_d == S_WR1) || (state_d == S_WAIT_WR1) || (state_d == S_RD2) ||
                     (state_d == S_WAIT_RD2) || (state_d == S_WR2) || (state_d == S_WAIT_WR2);
        den_d  = (state_d == S_RD1) || (state_d == S_WR1) || (state_d == S_RD2) || (state_d == S_WR2);
        dwe_d  = (state_d == S_WR1) || (state_d == S_WR2);
        done_d = (state_q == S_DONE);
        err_d  = (state_q == S_DONE) ? pend_err_q : err_q;

        daddr_d = daddr_q;
        di_d    = di_q;
        case (state_d)
            S_RD1:   daddr_d = reg1_addr(sel_q);
            S_RD2:   daddr_d = reg1_addr(sel_q) | 7'd1;
            S_WR1:   di_d    = merge_reg1(do_i, div_q);
            S_WR2:   di_d    = merge_reg2(do_i, div_q);
            default: ;
        endcase
    end

    // State and output registers; reset parks the MMCM in reset with DRP idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_POR;
            timer_q     <= '0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            lock_seen_q <= 1'b0;
            por_q       <= 1'b1;
            sel_q       <= 3'd0;
            div_q       <= 8'd0;
            pend_err_q  <= 2'd0;
            err_q       <= 2'd0;
            done_q      <= 1'b0;
            mmcm_rst_q  <= 1'b1;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            daddr_q     <= 7'd0;
            di_q        <= 16'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            lock_seen_q <= lock_seen_d;
            por_q       <= por_d;
            sel_q       <= sel_d;
            div_q       <= div_d;
            pend_err_q  <= pend_err_d;
            err_q       <= err_d;
            done_q      <= done_d;
            mmcm_rst_q  <= mmcm_rst_d;
            den_q       <= den_d;
            dwe_q       <= dwe_d;
            daddr_q     <= daddr_d;
            di_q        <= di_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign clk_good  = sync2_q && (state_q == S_IDLE);
    assign sys_rst   = ~clk_good;
    assign done      = done_q;
    assign err_code  = err_q;
    assign mmcm_rst  = mmcm_rst_q;
    assign den       = den_q;
    assign dwe       = dwe_q;
    assign daddr     = daddr_q;
    assign di        = di_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Bench for mmcm_drp_sequencer: MMCM lock model, DRP register model and a
// scoreboard of expected DRP writes.
module tb_mmcm_drp_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_req;
    logic [2:0]  cfg_out_sel;
    logic [7:0]  cfg_divide;
    logic        busy, done, clk_good, sys_rst, mmcm_rst;
    logic [1:0]  err_code;
    logic        mmcm_locked = 1'b0;
    logic [6:0]  daddr;
    logic        den, dwe;
    logic [15:0] di;
    logic [15:0] do_i = 16'h0000;
    logic        drdy = 1'b0;
    logic [3:0]  dbg_state;

    int n_chk = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int den_cnt = 0;

    logic [22:0] exp_q[$];
    logic [15:0] drp_mem[0:127];
    logic [15:0] mem_rd = 16'h0000;
    bit          pend = 1'b0;
    bit          drp_stall = 1'b0;
    bit          lock_allowed = 1'b1;
    int          lock_lat = 100;
    int          lock_cnt = 0;

    mmcm_drp_sequencer #(.DRP_TIMEOUT(64), .LOCK_TIMEOUT(4000)) dut (
        .clk(clk), .rst(rst), .cfg_req(cfg_req), .cfg_out_sel(cfg_out_sel),
        .cfg_divide(cfg_divide), .busy(busy), .done(done), .err_code(err_code),
        .clk_good(clk_good), .sys_rst(sys_rst), .mmcm_rst(mmcm_rst),
        .mmcm_locked(mmcm_locked), .daddr(daddr), .den(den), .dwe(dwe), .di(di),
        .do_i(do_i), .drdy(drdy), .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [6:0] exp_addr(input logic [2:0] s);
        case (s)
            3'd0: return 7'h08;
            3'd1: return 7'h0A;
            3'd2: return 7'h0C;
            3'd3: return 7'h0E;
            3'd4: return 7'h10;
            3'd5: return 7'h06;
            default: return 7'h12;
        endcase
    endfunction

    function automatic logic [15:0] model_r1(input int d, input logic [15:0] rd);
        int hi, lo;
        hi = d / 2;
        lo = d - hi;
        if (d == 1) begin hi = 1; lo = 1; end
        return (rd & 16'hF000) | 16'((hi % 64) * 64) | 16'(lo % 64);
    endfunction

    function automatic logic [15:0] model_r2(input int d, input logic [15:0] rd);
        logic [15:0] v;
        v = rd & 16'hFF3F;
        if ((d % 2 == 1) && (d != 1)) v = v | 16'h0080;
        if (d == 1) v = v | 16'h0040;
        return v;
    endfunction

    // MMCM lock model and DRP register model, stepped on the falling edge.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mmcm_rst || !lock_allowed) begin
            mmcm_locked = 1'b0;
            lock_cnt = 0;
        end else if (lock_cnt >= lock_lat) begin
            mmcm_locked = 1'b1;
        end else begin
            lock_cnt++;
        end
        drdy = 1'b0;
        if (pend) begin
            if (!drp_stall) begin
                drdy = 1'b1;
                do_i = mem_rd;
            end
            pend = 1'b0;
        end
        if (den) begin
            den_cnt++;
            chk("rst_at_den", {31'd0, mmcm_rst}, 32'd1);
            if (dwe) begin
                drp_mem[daddr] = di;
                chk("wr_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    logic [22:0] e;
                    e = exp_q.pop_front();
                    chk("wr_addr", {25'd0, daddr}, {25'd0, e[22:16]});
                    chk("wr_data", {16'd0, di}, {16'd0, e[15:0]});
                end
            end else begin
                mem_rd = drp_mem[daddr];
            end
            pend = 1'b1;
        end
    end

    // One request: preload readbacks, push expected writes, wait for done.
    task automatic do_cfg(input string tag, input logic [2:0] sel, input logic [7:0] d,
                          input logic [15:0] rd1, input logic [15:0] rd2,
                          input logic [15:0] w1, input logic [15:0] w2,
                          input logic [1:0] exp_err, input bit writes, input bit exp_good,
                          output int rst_cycles);
        logic [6:0] a1;
        int d0, cnt;
        a1 = exp_addr(sel);
        if (sel != 3'd7) begin
            drp_mem[a1] = rd1;
            drp_mem[a1 | 7'd1] = rd2;
        end
        if (writes) begin
            exp_q.push_back({a1, w1});
            exp_q.push_back({a1 | 7'd1, w2});
        end
        d0 = den_cnt;
        rst_cycles = 0;
        cfg_out_sel = sel;
        cfg_divide = d;
        cfg_req = 1'b1;
        step();
        cfg_req = 1'b0;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        cnt = 0;
        while (!done && cnt < 6000) begin
            if (mmcm_rst) rst_cycles++;
            step();
            cnt++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_err"}, {30'd0, err_code}, {30'd0, exp_err});
        chk({tag, "_sb_empty"}, exp_q.size(), 32'd0);
        chk({tag, "_good"}, {31'd0, clk_good}, {31'd0, exp_good});
        if (!writes && exp_err == 2'd1) begin
            chk({tag, "_no_den"}, den_cnt - d0, 32'd0);
            chk({tag, "_no_mrst"}, rst_cycles, 32'd0);
        end
        exp_q.delete();
        step();
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_err_hold"}, {30'd0, err_code}, {30'd0, exp_err});
    endtask

    initial begin
        int lat, rc, cnt;
        int dc0;
        logic [2:0] rs;
        int rdv;
        logic [15:0] r1, r2;

        for (int i = 0; i < 128; i++) drp_mem[i] = 16'h0000;
        rst = 1'b1;
        cfg_req = 1'b0;
        cfg_out_sel = 3'd0;
        cfg_divide = 8'd1;

        // reset values
        repeat (3) step();
        chk("rst_mmcm_rst", {31'd0, mmcm_rst}, 32'd1);
        chk("rst_sys_rst", {31'd0, sys_rst}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_clk_good", {31'd0, clk_good}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {30'd0, err_code}, 32'd0);
        chk("rst_den_dwe", {30'd0, den, dwe}, 32'd0);
        chk("rst_daddr_di", {9'd0, daddr, di}, 32'd0);

        // power-up: locked appears 100 cycles after mmcm_rst drops
        rst = 1'b0;
        cnt = 0;
        while (!mmcm_locked && cnt < 300) begin step(); cnt++; end
        chk("pwr_locked_seen", {31'd0, mmcm_locked}, 32'd1);
        chk("pwr_good_early", {31'd0, clk_good}, 32'd0);
        lat = 0;
        while (!clk_good && lat < 20) begin step(); lat++; end
        chk("pwr_latency", {31'd0, lat >= 3 && lat <= 5}, 32'd1);
        chk("pwr_sys_rst", {31'd0, sys_rst}, 32'd0);
        chk("pwr_no_done", done_cnt, 32'd0);
        chk("pwr_err", {30'd0, err_code}, 32'd0);
        chk("pwr_idle", {31'd0, busy}, 32'd0);
        lock_lat = 3;
        step();

        // reconfiguration with known encodings
        do_cfg("d64", 3'd2, 8'd64, 16'h1FFF, 16'h00C0, 16'h1820, 16'h0000, 2'd0, 1'b1, 1'b1, rc);
        do_cfg("d5", 3'd1, 8'd5, 16'h0000, 16'h0000, 16'h0083, 16'h0080, 2'd0, 1'b1, 1'b1, rc);
        do_cfg("d1", 3'd6, 8'd1, 16'hFFFF, 16'hFFFF, 16'hF041, 16'hFF7F, 2'd0, 1'b1, 1'b1, rc);
        do_cfg("d128", 3'd3, 8'd128, 16'h0ABC, 16'h0ABC, 16'h0000, 16'h0A3C, 2'd0, 1'b1, 1'b1, rc);

        // random legal requests checked against the encoding model
        for (int i = 0; i < 3; i++) begin
            rs = 3'($urandom_range(0, 6));
            rdv = $urandom_range(1, 128);
            r1 = 16'($urandom);
            r2 = 16'($urandom);
            do_cfg("rnd", rs, 8'(rdv), r1, r2, model_r1(rdv, r1), model_r2(rdv, r2),
                   2'd0, 1'b1, 1'b1, rc);
        end

        // illegal arguments
        do_cfg("sel7", 3'd7, 8'd10, 16'h0, 16'h0, 16'h0, 16'h0, 2'd1, 1'b0, 1'b1, rc);
        do_cfg("div0", 3'd0, 8'd0, 16'h0, 16'h0, 16'h0, 16'h0, 2'd1, 1'b0, 1'b1, rc);
        do_cfg("div129", 3'd4, 8'd129, 16'h0, 16'h0, 16'h0, 16'h0, 2'd1, 1'b0, 1'b1, rc);

        // drdy never returns
        drp_stall = 1'b1;
        do_cfg("drdy_to", 3'd0, 8'd10, 16'h0, 16'h0, 16'h0, 16'h0, 2'd2, 1'b0, 1'b1, rc);
        chk("drdy_to_rst_len", {31'd0, rc >= 64 && rc <= 70}, 32'd1);
        drp_stall = 1'b0;

        // lock never returns
        lock_allowed = 1'b0;
        do_cfg("lock_to", 3'd4, 8'd20, 16'h1234, 16'h5678, model_r1(20, 16'h1234),
               model_r2(20, 16'h5678), 2'd3, 1'b1, 1'b0, rc);
        lock_allowed = 1'b1;
        cnt = 0;
        while (!clk_good && cnt < 50) begin step(); cnt++; end
        chk("relock_idle_good", {31'd0, clk_good}, 32'd1);

        // asynchronous reset during WAIT_WR1
        drp_mem[7'h06] = 16'h0000;
        exp_q.push_back({7'h06, model_r1(7, 16'h0000)});
        cfg_out_sel = 3'd5;
        cfg_divide = 8'd7;
        cfg_req = 1'b1;
        step();
        cfg_req = 1'b0;
        cnt = 0;
        while (dbg_state != 4'd7 && cnt < 100) begin step(); cnt++; end
        chk("mid_reached", {28'd0, dbg_state}, 32'd7);
        dc0 = done_cnt;
        rst = 1'b1;
        #1;
        chk("mid_mmcm_rst", {31'd0, mmcm_rst}, 32'd1);
        chk("mid_sys_rst", {31'd0, sys_rst}, 32'd1);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_outs", {27'd0, clk_good, done, err_code, den}, 32'd0);
        chk("mid_drp", {8'd0, dwe, daddr, di}, 32'd0);
        exp_q.delete();
        repeat (2) step();
        rst = 1'b0;
        cnt = 0;
        while (!clk_good && cnt < 200) begin step(); cnt++; end
        chk("mid_relock", {31'd0, clk_good}, 32'd1);
        chk("mid_no_done", done_cnt - dc0, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
